// File: rtl/mc_pkg.sv
// mc_pkg: shared states, ALU op codes, opcodes, mux encodings and branch helpers for mc_control
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECR, S_EXECI,
    S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_LUI, S_AUIPC, S_TRAP
  } state_t;

  localparam logic [4:0] ALU_ADD  = 5'b00000;
  localparam logic [4:0] ALU_SUB  = 5'b10001;
  localparam logic [4:0] ALU_AND  = 5'b00010;
  localparam logic [4:0] ALU_OR   = 5'b00011;
  localparam logic [4:0] ALU_XOR  = 5'b00100;
  localparam logic [4:0] ALU_SLT  = 5'b00101;
  localparam logic [4:0] ALU_SLL  = 5'b00110;
  localparam logic [4:0] ALU_SRL  = 5'b00111;
  localparam logic [4:0] ALU_SRA  = 5'b01000;
  localparam logic [4:0] ALU_SLTU = 5'b01001;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  // funct3 010/011 are not defined branch conditions
  function automatic logic branch_legal(input logic [2:0] funct3);
    return funct3[2:1] != 2'b01;
  endfunction

  // flags come from rs1 - rs2, nzcv = {N,Z,C,V}
  function automatic logic branch_taken(input logic [2:0] funct3, input logic [3:0] nzcv);
    case (funct3)
      3'b000:  return nzcv[2];
      3'b001:  return !nzcv[2];
      3'b100:  return nzcv[3] ^ nzcv[0];
      3'b101:  return !(nzcv[3] ^ nzcv[0]);
      3'b110:  return !nzcv[1];
      3'b111:  return nzcv[1];
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_dec.sv
// alu_dec: maps funct3/funct7b5 to an ALUControl code, with add/sub overrides from the FSM
module alu_dec
  import mc_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       is_rtype,
  input  logic       force_add,
  input  logic       force_sub,
  output logic [4:0] alu_control
);

  logic [4:0] op;

  // funct7b5 only selects sub for register-register ops, but selects sra for both forms
  always_comb begin
    op = ALU_ADD;
    case (funct3)
      3'b000: op = is_rtype && funct7b5 ? ALU_SUB : ALU_ADD;
      3'b001: op = ALU_SLL;
      3'b010: op = ALU_SLT;
      3'b011: op = ALU_SLTU;
      3'b100: op = ALU_XOR;
      3'b101: op = funct7b5 ? ALU_SRA : ALU_SRL;
      3'b110: op = ALU_OR;
      3'b111: op = ALU_AND;
    endcase
  end

  assign alu_control = force_sub ? ALU_SUB : force_add ? ALU_ADD : op;

endmodule

// File: rtl/mc_control.sv
// mc_control: multi-cycle RV32I control FSM; MC_CONTROL_ILLEGAL_TRAP_EN selects TRAP vs NOP on illegal instructions
module mc_control
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic [3:0] nzcv,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       adr_src,
  output logic       pc_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] result_src,
  output logic [2:0] imm_src,
  output logic [4:0] ALUControl,
  output logic       illegal
);

`ifdef MC_CONTROL_ILLEGAL_TRAP_EN
  localparam state_t S_ILL = S_TRAP;
`else
  localparam state_t S_ILL = S_FETCH;
`endif

  state_t state, next, cur;
  logic req, we, pcw, irw, rw;

  // reset forces FETCH into the output decode so non-strobe outputs show FETCH values
  assign cur = reset_n ? state : S_FETCH;

  // state register with synchronous active-low reset
  always_ff @(posedge clk) state <= reset_n ? next : S_FETCH;

  // next-state and Moore output decode; strobes are masked by reset below
  always_comb begin
    next = cur;
    req = 1'b0;
    we = 1'b0;
    pcw = 1'b0;
    irw = 1'b0;
    rw = 1'b0;
    adr_src = 1'b0;
    alu_src_a = SRCA_PC;
    alu_src_b = SRCB_RS2;
    result_src = RES_ALUOUT;
    case (cur)
      S_FETCH: begin
        req = 1'b1;
        alu_src_b = SRCB_FOUR;
        result_src = RES_ALU;
        irw = mem_ready;
        pcw = mem_ready;
        next = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        case (opcode)
          OP_LOAD, OP_STORE: next = S_MEMADR;
          OP_R:              next = S_EXECR;
          OP_I:              next = S_EXECI;
          OP_BRANCH:         next = S_BRANCH;
          OP_JAL:            next = S_JAL;
          OP_JALR:           next = S_JALR;
          OP_LUI:            next = S_LUI;
          OP_AUIPC:          next = S_AUIPC;
          default:           next = S_ILL;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        next = opcode == OP_LOAD ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        req = 1'b1;
        adr_src = 1'b1;
        next = mem_ready ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        result_src = RES_DATA;
        rw = 1'b1;
        next = S_FETCH;
      end
      S_MEMWRITE: begin
        req = 1'b1;
        we = 1'b1;
        adr_src = 1'b1;
        next = mem_ready ? S_FETCH : S_MEMWRITE;
      end
      S_EXECR: begin
        alu_src_a = SRCA_RS1;
        next = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        next = S_ALUWB;
      end
      S_ALUWB: begin
        rw = 1'b1;
        next = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = SRCA_RS1;
        pcw = branch_legal(funct3) && branch_taken(funct3, nzcv);
        next = branch_legal(funct3) ? S_FETCH : S_ILL;
      end
      S_JALR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        next = S_JAL;
      end
      S_JAL: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_FOUR;
        pcw = 1'b1;
        next = S_ALUWB;
      end
      S_LUI: begin
        alu_src_a = SRCA_ZERO;
        alu_src_b = SRCB_IMM;
        next = S_ALUWB;
      end
      S_AUIPC: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        next = S_ALUWB;
      end
      S_TRAP: next = S_TRAP;
      default: next = S_FETCH;
    endcase
  end

  // immediate format depends on opcode alone so it is valid as soon as IR loads
  always_comb begin
    imm_src = IMM_I;
    case (opcode)
      OP_STORE:         imm_src = IMM_S;
      OP_BRANCH:        imm_src = IMM_B;
      OP_JAL:           imm_src = IMM_J;
      OP_LUI, OP_AUIPC: imm_src = IMM_U;
      default:          imm_src = IMM_I;
    endcase
  end

  alu_dec u_alu_dec (
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .is_rtype    (cur == S_EXECR),
    .force_add   (!(cur inside {S_EXECR, S_EXECI, S_BRANCH})),
    .force_sub   (cur == S_BRANCH),
    .alu_control (ALUControl)
  );

  assign mem_req = reset_n && req;
  assign mem_we = reset_n && we;
  assign pc_write = reset_n && pcw;
  assign ir_write = reset_n && irw;
  assign reg_write = reset_n && rw;

`ifdef MC_CONTROL_ILLEGAL_TRAP_EN
  assign illegal = reset_n && state == S_TRAP;
`else
  assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_mc_control.sv
// tb_mc_control: per-instruction cycle-sequence model of mc_control with a per-cycle compare
module tb_mc_control;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [6:0] opcode = 7'd0;
  logic [2:0] funct3 = 3'd0;
  logic funct7b5 = 1'b0;
  logic [3:0] nzcv = 4'd0;
  logic mem_ready = 1'b0;
  logic mem_req, mem_we, adr_src, pc_write, ir_write, reg_write, illegal;
  logic [1:0] alu_src_a, alu_src_b, result_src;
  logic [2:0] imm_src;
  logic [4:0] ALUControl;

  mc_control dut (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
    .nzcv(nzcv), .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .adr_src(adr_src),
    .pc_write(pc_write), .ir_write(ir_write), .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .result_src(result_src), .imm_src(imm_src), .ALUControl(ALUControl),
    .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0] s;
    logic [1:0] a, b, res;
    logic [2:0] imm;
    logic [4:0] alu;
    logic ill;
  } out_t;

  typedef struct packed {
    logic rst_n, rdy;
    logic [6:0] op;
    logic [2:0] f3;
    logic f7;
    logic [3:0] nz;
    out_t o;
  } rec_t;

  rec_t q[$];
  out_t exp_o, got_o;
  logic chk = 1'b0;
  int n_cmp = 0, n_bad = 0, cyc = 0;
  logic [6:0] c_op = 7'd0;
  logic [2:0] c_f3 = 3'd0;
  logic c_f7 = 1'b0;
  logic [3:0] c_nz = 4'd0;

  // strobe groups {mem_req, mem_we, adr_src, pc_write, ir_write, reg_write}
  localparam logic [5:0] NONE = 6'b000000, F_WAIT = 6'b100000, F_DONE = 6'b100110;
  localparam logic [5:0] RD = 6'b101000, WR = 6'b111000, WB = 6'b000001, PCW = 6'b000100;

  assign got_o = {mem_req, mem_we, adr_src, pc_write, ir_write, reg_write,
                  alu_src_a, alu_src_b, result_src, imm_src, ALUControl, illegal};

  function automatic logic [2:0] imm_of(input logic [6:0] op);
    case (op)
      7'b0100011: return 3'b001;
      7'b1100011: return 3'b010;
      7'b1101111: return 3'b011;
      7'b0110111, 7'b0010111: return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [4:0] alu_of(input logic [2:0] f3, input logic f7, input logic rt);
    case (f3)
      3'd0: return (rt && f7) ? 5'b10001 : 5'b00000;
      3'd1: return 5'b00110;
      3'd2: return 5'b00101;
      3'd3: return 5'b01001;
      3'd4: return 5'b00100;
      3'd5: return f7 ? 5'b01000 : 5'b00111;
      3'd6: return 5'b00011;
      default: return 5'b00010;
    endcase
  endfunction

  function automatic logic taken_of(input logic [2:0] f3, input logic [3:0] nz);
    logic n, z, c, v;
    {n, z, c, v} = nz;
    case (f3)
      3'd0: return z;
      3'd1: return !z;
      3'd4: return n != v;
      3'd5: return n == v;
      3'd6: return !c;
      default: return c;
    endcase
  endfunction

  task automatic push(input logic rst_n, input logic rdy, input logic [5:0] s, input logic [1:0] a,
                      input logic [1:0] b, input logic [1:0] res, input logic [4:0] alu, input logic ill);
    rec_t r;
    r.rst_n = rst_n;
    r.rdy = rdy;
    r.op = c_op;
    r.f3 = c_f3;
    r.f7 = c_f7;
    r.nz = c_nz;
    r.o = {s, a, b, res, imm_of(c_op), alu, ill};
    q.push_back(r);
  endtask

  task automatic rst_cycles(input int n);
    repeat (n) push(1'b0, 1'b1, NONE, 2'd0, 2'd2, 2'd2, 5'd0, 1'b0);
  endtask

  task automatic pin(input string name, input int got, input int req);
    n_cmp++;
    if (got != req) begin
      n_bad++;
      $display("FAIL pin %s: got %0d, required %0d", name, got, req);
    end
  endtask

  task automatic illegal_tail();
`ifdef MC_CONTROL_ILLEGAL_TRAP_EN
    repeat (3) push(1'b1, 1'b1, NONE, 2'd0, 2'd0, 2'd0, 5'd0, 1'b1);
    rst_cycles(1);
`endif
  endtask

  task automatic aluwb();
    push(1'b1, 1'b1, WB, 2'd0, 2'd0, 2'd0, 5'd0, 1'b0);
  endtask

  task automatic jal_step();
    push(1'b1, 1'b1, PCW, 2'd1, 2'd2, 2'd0, 5'd0, 1'b0);
    aluwb();
  endtask

  // expand one instruction into its expected cycles; wf/wm = fetch/data wait cycles
  task automatic run(input logic [6:0] op, input logic [2:0] f3, input logic f7, input logic [3:0] nz,
                     input int wf, input int wm, input int cycles);
    int s0;
    s0 = q.size();
    c_op = op;
    c_f3 = f3;
    c_f7 = f7;
    c_nz = nz;
    repeat (wf) push(1'b1, 1'b0, F_WAIT, 2'd0, 2'd2, 2'd2, 5'd0, 1'b0);
    push(1'b1, 1'b1, F_DONE, 2'd0, 2'd2, 2'd2, 5'd0, 1'b0);
    push(1'b1, 1'b1, NONE, 2'd1, 2'd1, 2'd0, 5'd0, 1'b0);
    case (op)
      7'b0110011: begin
        push(1'b1, 1'b1, NONE, 2'd2, 2'd0, 2'd0, alu_of(f3, f7, 1'b1), 1'b0);
        aluwb();
      end
      7'b0010011: begin
        push(1'b1, 1'b1, NONE, 2'd2, 2'd1, 2'd0, alu_of(f3, f7, 1'b0), 1'b0);
        aluwb();
      end
      7'b0000011: begin
        push(1'b1, 1'b1, NONE, 2'd2, 2'd1, 2'd0, 5'd0, 1'b0);
        repeat (wm) push(1'b1, 1'b0, RD, 2'd0, 2'd0, 2'd0, 5'd0, 1'b0);
        push(1'b1, 1'b1, RD, 2'd0, 2'd0, 2'd0, 5'd0, 1'b0);
        push(1'b1, 1'b1, WB, 2'd0, 2'd0, 2'd1, 5'd0, 1'b0);
      end
      7'b0100011: begin
        push(1'b1, 1'b1, NONE, 2'd2, 2'd1, 2'd0, 5'd0, 1'b0);
        repeat (wm) push(1'b1, 1'b0, WR, 2'd0, 2'd0, 2'd0, 5'd0, 1'b0);
        push(1'b1, 1'b1, WR, 2'd0, 2'd0, 2'd0, 5'd0, 1'b0);
      end
      7'b1100011: begin
        if (f3 == 3'd2 || f3 == 3'd3) begin
          push(1'b1, 1'b1, NONE, 2'd2, 2'd0, 2'd0, 5'b10001, 1'b0);
          illegal_tail();
        end else
          push(1'b1, 1'b1, taken_of(f3, nz) ? PCW : NONE, 2'd2, 2'd0, 2'd0, 5'b10001, 1'b0);
      end
      7'b1101111: jal_step();
      7'b1100111: begin
        push(1'b1, 1'b1, NONE, 2'd2, 2'd1, 2'd0, 5'd0, 1'b0);
        jal_step();
      end
      7'b0110111: begin
        push(1'b1, 1'b1, NONE, 2'd3, 2'd1, 2'd0, 5'd0, 1'b0);
        aluwb();
      end
      7'b0010111: begin
        push(1'b1, 1'b1, NONE, 2'd1, 2'd1, 2'd0, 5'd0, 1'b0);
        aluwb();
      end
      default: illegal_tail();
    endcase
    if (cycles > 0) pin($sformatf("cycles op=%b f3=%b", op, f3), q.size() - s0, cycles);
  endtask

  always @(negedge clk) begin
    if (chk) begin
      n_cmp++;
      if (got_o !== exp_o) begin
        n_bad++;
        $display("FAIL cycle %0d op=%b f3=%b: got strobes=%b a=%b b=%b res=%b imm=%b alu=%b ill=%b, required strobes=%b a=%b b=%b res=%b imm=%b alu=%b ill=%b",
                 cyc, opcode, funct3, got_o.s, got_o.a, got_o.b, got_o.res, got_o.imm, got_o.alu, got_o.ill,
                 exp_o.s, exp_o.a, exp_o.b, exp_o.res, exp_o.imm, exp_o.alu, exp_o.ill);
      end
    end
  end

  initial begin
    pin("alu add", int'(alu_of(3'd0, 1'b0, 1'b1)), 0);
    pin("alu sub", int'(alu_of(3'd0, 1'b1, 1'b1)), 17);
    pin("alu srai", int'(alu_of(3'd5, 1'b1, 1'b0)), 8);
    pin("alu addi f7", int'(alu_of(3'd0, 1'b1, 1'b0)), 0);
    pin("bltu 0000", int'(taken_of(3'd6, 4'b0000)), 1);
    pin("bge 1000", int'(taken_of(3'd5, 4'b1000)), 0);
    rst_cycles(2);
    run(7'b0110011, 3'd0, 1'b0, 4'd0, 0, 0, 4);
    run(7'b0110011, 3'd0, 1'b1, 4'd0, 1, 0, 5);
    run(7'b0000011, 3'd2, 1'b0, 4'd0, 0, 3, 8);
    run(7'b0000011, 3'd2, 1'b0, 4'd0, 0, 0, 5);
    run(7'b0100011, 3'd2, 1'b0, 4'd0, 0, 0, 4);
    run(7'b0100011, 3'd2, 1'b0, 4'd0, 2, 1, 7);
    run(7'b1100011, 3'd6, 1'b0, 4'b0000, 0, 0, 3);
    run(7'b1100011, 3'd5, 1'b0, 4'b1000, 0, 0, 3);
    run(7'b1100011, 3'd0, 1'b0, 4'b0100, 0, 0, 3);
    run(7'b1100011, 3'd1, 1'b0, 4'b0100, 0, 0, 3);
    run(7'b1100011, 3'd4, 1'b0, 4'b0001, 0, 0, 3);
    run(7'b1100011, 3'd7, 1'b0, 4'b0010, 0, 0, 3);
    run(7'b1100011, 3'd7, 1'b0, 4'b1101, 0, 0, 3);
    run(7'b0010011, 3'd5, 1'b1, 4'd0, 0, 0, 4);
    run(7'b0010011, 3'd0, 1'b1, 4'd0, 0, 0, 4);
    for (int i = 1; i < 8; i++) run(7'b0010011, 3'(i), 1'b0, 4'd0, 0, 0, 4);
    for (int i = 1; i < 8; i++) run(7'b0110011, 3'(i), 1'b1, 4'd0, 0, 0, 4);
    run(7'b0110111, 3'd0, 1'b0, 4'd0, 0, 0, 4);
    run(7'b0010111, 3'd0, 1'b0, 4'd0, 0, 0, 4);
    run(7'b1101111, 3'd0, 1'b0, 4'd0, 0, 0, 0);
    run(7'b1100111, 3'd0, 1'b0, 4'd0, 0, 0, 0);
    run(7'b0000011, 3'd2, 1'b0, 4'd0, 0, 3, 0);
    repeat (3) void'(q.pop_back());
    rst_cycles(1);
    run(7'b0000000, 3'd0, 1'b0, 4'd0, 0, 0, 0);
    run(7'b0110011, 3'd7, 1'b0, 4'd0, 0, 0, 4);
    run(7'b1100011, 3'd2, 1'b0, 4'b0100, 0, 0, 0);
    run(7'b0110011, 3'd6, 1'b0, 4'd0, 0, 0, 4);
    for (int i = 0; i < q.size(); i++) begin
      @(posedge clk);
      #1;
      reset_n = q[i].rst_n;
      mem_ready = q[i].rdy;
      opcode = q[i].op;
      funct3 = q[i].f3;
      funct7b5 = q[i].f7;
      nzcv = q[i].nz;
      exp_o = q[i].o;
      cyc = i;
      chk = 1'b1;
    end
    @(negedge clk);
    #1;
    chk = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
